// File: rtl/lut_neuron_loader_if.sv
// lut_neuron_loader_if: config stream and lookup bus of the loadable LUT neuron
interface lut_neuron_loader_if #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2
);
    logic                cfg_start;
    logic                cfg_valid;
    logic [OUT_BITS-1:0] cfg_data;
    logic                cfg_ready;
    logic                cfg_done;
    logic                in_valid;
    logic [IN_BITS-1:0]  in_data;
    logic                out_valid;
    logic [OUT_BITS-1:0] out_data;
    logic                lookup_err;

    modport master (
        output cfg_start, cfg_valid, cfg_data, in_valid, in_data,
        input  cfg_ready, cfg_done, out_valid, out_data, lookup_err
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, in_valid, in_data,
        output cfg_ready, cfg_done, out_valid, out_data, lookup_err
    );
endinterface

// File: rtl/lut_neuron_loader.sv
// lut_neuron_loader: runtime-loadable truth-table neuron with registered lookups
module lut_neuron_loader #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2
) (
    input logic clk,
    input logic rst_n,
    lut_neuron_loader_if.slave bus
);
    localparam int DEPTH = 2 ** IN_BITS;
    localparam logic [IN_BITS:0] LAST = (IN_BITS + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

    state_t              state, state_nxt;
    logic [IN_BITS:0]    idx, idx_nxt;
    logic [OUT_BITS-1:0] mem [DEPTH];
    logic                wr, fin, rd;

    assign bus.cfg_ready = (state == LOAD) && !bus.cfg_start;
    assign wr  = bus.cfg_valid && bus.cfg_ready;
    assign fin = wr && (idx == LAST);
    assign rd  = bus.in_valid && (state == READY);

    // next state and load index: cfg_start always wins and restarts at entry 0
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (bus.cfg_start) begin
            state_nxt = LOAD;
            idx_nxt   = '0;
        end else if (wr) begin
            idx_nxt = idx + 1'b1;
            if (fin) state_nxt = READY;
        end
    end

    // state, handshake pulses, registered lookup result and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= EMPTY;
            idx            <= '0;
            bus.cfg_done   <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.lookup_err <= 1'b0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            bus.cfg_done  <= fin;
            bus.out_valid <= rd;
            if (rd) bus.out_data <= mem[bus.in_data];
            if (bus.cfg_start) bus.lookup_err <= 1'b0;
            else if (bus.in_valid && state != READY) bus.lookup_err <= 1'b1;
        end
    end

    // table storage is left unreset so it maps onto distributed RAM
    always_ff @(posedge clk) begin
        if (wr) mem[idx[IN_BITS-1:0]] <= bus.cfg_data;
    end
endmodule

// File: tb/tb_lut_neuron_loader.sv
// tb_lut_neuron_loader: randomized scoreboard bench for the loadable LUT neuron
module tb_lut_neuron_loader;
    logic clk = 0;
    logic rst_n = 0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    lut_neuron_loader_if #(.IN_BITS(6), .OUT_BITS(2)) bus ();

    lut_neuron_loader #(.IN_BITS(6), .OUT_BITS(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // free-running cycle count used to time expectations
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] d;
    } exp_t;

    exp_t       sb[$];
    int         done_q[$];
    logic [1:0] last_out = 0;

    logic [1:0] tbl [64];
    int         m_idx = 0;
    bit         m_load = 0;
    bit         m_ready = 0;
    bit         m_err = 0;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
        end
    endtask

    // monitor: results and done pulses are matched against queued expectations
    always @(negedge clk) begin
        if (!rst_n) begin
            last_out = 0;
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                check("missed_out_valid", 0, 1);
                void'(sb.pop_front());
            end
            while (done_q.size() > 0 && done_q[0] < cyc) begin
                check("missed_cfg_done", 0, 1);
                void'(done_q.pop_front());
            end
            if (bus.out_valid) begin
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    check("out_data", bus.out_data, sb[0].d);
                    last_out = sb[0].d;
                    void'(sb.pop_front());
                end else begin
                    check("unexpected_out_valid", 1, 0);
                end
            end else begin
                check("out_data_hold", bus.out_data, last_out);
            end
            if (bus.cfg_done) begin
                if (done_q.size() > 0 && done_q[0] == cyc) begin
                    check("cfg_done", 1, 1 - (done_q[0] - cyc));
                    void'(done_q.pop_front());
                end else begin
                    check("unexpected_cfg_done", 1, 0);
                end
            end
        end
    end

    // one clock of stimulus; the model advances on the same edge as the DUT
    task automatic step(input bit st, input bit v, input logic [1:0] d, input bit iv, input logic [5:0] id);
        int ec;
        bus.cfg_start = st;
        bus.cfg_valid = v;
        bus.cfg_data  = d;
        bus.in_valid  = iv;
        bus.in_data   = id;
        #1;
        check("cfg_ready", bus.cfg_ready, m_load && !st);
        ec = cyc + 1;
        @(posedge clk);
        if (iv) begin
            if (m_ready) sb.push_back('{ec, tbl[id]});
            else m_err = 1;
        end
        if (m_load && !st && v) begin
            tbl[m_idx] = d;
            m_idx++;
            if (m_idx == 64) begin
                m_load  = 0;
                m_ready = 1;
                done_q.push_back(ec);
            end
        end
        if (st) begin
            m_load  = 1;
            m_ready = 0;
            m_idx   = 0;
            m_err   = 0;
        end
        #1;
        check("lookup_err", bus.lookup_err, m_err);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_cfg_done", bus.cfg_done, 0);
        check("rst_cfg_ready", bus.cfg_ready, 0);
        check("rst_lookup_err", bus.lookup_err, 0);
    endtask

    // asynchronous reset in the middle of a cycle, released after the next edge
    task automatic async_reset();
        bus.cfg_start = 0;
        bus.cfg_valid = 0;
        bus.in_valid  = 0;
        #2;
        rst_n = 0;
        #1;
        check_reset_outputs();
        m_load  = 0;
        m_ready = 0;
        m_idx   = 0;
        m_err   = 0;
        sb.delete();
        done_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic load_random(input int gap_pct);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 2000 && m_load; i++) begin
            logic [1:0] d;
            d = 2'($urandom);
            if (m_idx == 8 || m_idx == 41) d = 2'b11;
            step(0, $urandom_range(99) >= gap_pct, d, 0, 0);
        end
        check("load_finished", m_ready, 1);
    endtask

    initial begin
        bus.cfg_start = 0;
        bus.cfg_valid = 0;
        bus.cfg_data  = 0;
        bus.in_valid  = 0;
        bus.in_data   = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1;

        step(0, 0, 0, 1, 6'd5);
        idle();

        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) step(0, 1, 2'(i), 0, 0);
        repeat (3) idle();

        step(0, 0, 0, 1, 6'd37);
        step(0, 0, 0, 1, 6'd38);
        step(0, 0, 0, 1, 6'd63);
        idle();
        check("tbl37", tbl[37], 2'b01);
        check("tbl63", tbl[63], 2'b11);

        load_random(50);
        step(0, 1, 2'b00, 0, 0);
        step(0, 1, 2'b01, 0, 0);
        for (int i = 0; i < 64; i++) step(0, 0, 0, 1, 6'(i));
        for (int i = 0; i < 40; i++) step(0, $urandom_range(1), 2'($urandom), 1, 6'($urandom));
        idle();

        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 2'($urandom), $urandom_range(3) == 0, 6'($urandom));
        step(1, 1, 2'b10, 0, 0);
        for (int i = 0; i < 64; i++) step(0, 1, 2'($urandom), 0, 0);
        repeat (2) idle();
        for (int i = 0; i < 64; i++) step(0, 0, 0, 1, 6'(i));
        idle();

        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 2'($urandom), 0, 0);
        async_reset();
        step(0, 0, 0, 1, 6'd9);
        idle();

        load_random(30);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 6'($urandom));
        async_reset();
        step(0, 0, 0, 1, 6'd20);
        step(0, 0, 0, 1, 6'd21);
        repeat (3) idle();

        check("scoreboard_drained", sb.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
